// File: rtl/ofdm_tx_pkg.sv
// Shared constants and state encoding for the OFDM Tx symbol scheduler.
package ofdm_tx_pkg;

    localparam int WORD_W        = 32;
    localparam int WORDS_PER_SYM = 7;
    localparam int SYM_W         = WORD_W * WORDS_PER_SYM;
    localparam int NSYM_W        = 8;

    localparam logic [SYM_W-1:0] PREAMBLE_DEF = {WORDS_PER_SYM{32'hA5A5_5A5A}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_FILL  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_PAD   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/ofdm_tx_word_packer.sv
// Slot register that assembles WORDS_PER_SYM input words into one symbol.
module ofdm_tx_word_packer
    import ofdm_tx_pkg::*;
#(
    parameter int WP_WORD_W = WORD_W,
    parameter int WP_WORDS  = WORDS_PER_SYM
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic                              clr_i,
    input  logic                              load_i,
    input  logic [WP_WORD_W-1:0]              data_i,
    output logic [WP_WORDS-1:0][WP_WORD_W-1:0] slots_o,
    output logic                              full_o
);

    localparam int WCNT_W = (WP_WORDS > 1) ? $clog2(WP_WORDS) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WP_WORDS - 1);

    logic [WP_WORDS-1:0][WP_WORD_W-1:0] slot_q;
    logic [WCNT_W-1:0]                  wcnt_q;

    // full_o flags the load that completes the symbol, so the FSM can issue next cycle
    assign full_o  = load_i && (wcnt_q == WCNT_LAST);
    assign slots_o = slot_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot_q <= '0;
            wcnt_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
            wcnt_q <= '0;
        end else if (load_i) begin
            for (int k = 0; k < WP_WORDS; k++) begin
                if (wcnt_q == WCNT_W'(k)) slot_q[k] <= data_i;
            end
            wcnt_q <= full_o ? '0 : wcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ofdm_tx_symbol_scheduler.sv
// Frame sequencer: preamble, word packing, zero padding to cfg_nsym symbols, overlength drain.
module ofdm_tx_symbol_scheduler
    import ofdm_tx_pkg::*;
#(
    parameter int                            P_WORD_W        = WORD_W,
    parameter int                            P_WORDS_PER_SYM = WORDS_PER_SYM,
    parameter int                            P_NSYM_W        = NSYM_W,
    parameter bit                            PREAMBLE_EN     = 1'b1,
    parameter logic [P_WORD_W*P_WORDS_PER_SYM-1:0] PREAMBLE   = PREAMBLE_DEF
) (
    input  logic                                   clk,
    input  logic                                   nreset,
    input  logic                                   enable,
    input  logic [P_NSYM_W-1:0]                    cfg_nsym,
    input  logic [P_WORD_W-1:0]                    s_data,
    input  logic                                   s_valid,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [P_WORD_W*P_WORDS_PER_SYM-1:0]    sym,
    output logic                                   sym_valid,
    input  logic                                   sym_wready,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic [15:0]                            frame_cnt,
    output logic                                   err_long,
    input  logic                                   err_clr
);

    localparam int L_SYM_W = P_WORD_W * P_WORDS_PER_SYM;

    state_e                                    state_q, state_d;
    logic [P_NSYM_W-1:0]                       nsym_q, nsym_d;
    logic [P_NSYM_W-1:0]                       sym_cnt_q, sym_cnt_d;
    logic                                      last_q, last_d;
    logic                                      err_q;
    logic [15:0]                               fcnt_q;
    logic                                      err_set;
    logic                                      pk_clr, pk_load, pk_full;
    logic [P_WORDS_PER_SYM-1:0][P_WORD_W-1:0]  pk_slots;
    logic                                      xfer, cnt_hit;

    ofdm_tx_word_packer #(
        .WP_WORD_W (P_WORD_W),
        .WP_WORDS  (P_WORDS_PER_SYM)
    ) u_packer (
        .clk     (clk),
        .nreset  (nreset),
        .clr_i   (pk_clr),
        .load_i  (pk_load),
        .data_i  (s_data),
        .slots_o (pk_slots),
        .full_o  (pk_full)
    );

    // Outputs decode straight from the state register, so they are glitch-free and
    // cannot move while a symbol waits for sym_wready.
    assign sym_valid  = (state_q == ST_PRE) || (state_q == ST_ISSUE) || (state_q == ST_PAD);
    assign sym        = (state_q == ST_PRE)   ? PREAMBLE :
                        (state_q == ST_ISSUE) ? L_SYM_W'(pk_slots) : '0;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign frame_cnt  = fcnt_q;
    assign err_long   = err_q;

    assign xfer    = sym_valid && sym_wready;
    assign cnt_hit = ({1'b0, sym_cnt_q} + 1'b1) == {1'b0, nsym_q};

    always_comb begin
        state_d   = state_q;
        nsym_d    = nsym_q;
        sym_cnt_d = sym_cnt_q;
        last_d    = last_q;
        s_ready   = 1'b0;
        pk_clr    = 1'b0;
        pk_load   = 1'b0;
        err_set   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && s_valid) begin
                    nsym_d    = (cfg_nsym == '0) ? P_NSYM_W'(1) : cfg_nsym;
                    sym_cnt_d = '0;
                    last_d    = 1'b0;
                    if (PREAMBLE_EN) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d = ST_FILL;
                        pk_clr  = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (xfer) begin
                    state_d = ST_FILL;
                    pk_clr  = 1'b1;
                end
            end
            ST_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pk_load = 1'b1;
                    last_d  = s_last;
                    if (pk_full || s_last) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                    if (cnt_hit) begin
                        if (last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            err_set = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (last_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FILL;
                        pk_clr  = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                if (xfer) begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                    if (cnt_hit) state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            nsym_q    <= '0;
            sym_cnt_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nsym_q    <= nsym_d;
            sym_cnt_q <= sym_cnt_d;
            last_q    <= last_d;
        end
    end

    // A new overlength event beats a same-cycle clear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q  <= 1'b0;
            fcnt_q <= '0;
        end else begin
            if (err_set)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            if (state_q == ST_DONE) fcnt_q <= fcnt_q + 16'd1;
        end
    end

endmodule
